// File: rtl/axi_dw_allocator_pkg.sv
// Shared widths and the W beat struct for the master-port write-data allocator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_dw_allocator_pkg;

  localparam int AXI_DW_DATA_W = 64;
  localparam int AXI_DW_USER_W = 6;
  localparam int AXI_DW_STRB_W = AXI_DW_DATA_W / 8;

  // One W beat; the source mux and the optional skid buffer both move this type.
  typedef struct packed {
    logic [AXI_DW_DATA_W-1:0] data;
    logic [AXI_DW_STRB_W-1:0] strb;
    logic [AXI_DW_USER_W-1:0] user;
    logic                     last;
  } w_beat_t;

endpackage

// File: rtl/axi_dw_allocator_fifo.sv
// Generic synchronous FIFO, used here to hold one-hot AW grant sources.
// Latency: 1 cycle push-to-pop_vld, no bypass.
// Backpressure: push_rdy low when full; a push while full is dropped.
// Ports: push_vld/push_dat/push_rdy write side, pop_vld/pop_dat/pop_rdy read side.
module axi_dw_allocator_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DATA_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_vld,
  input  logic [DATA_WIDTH-1:0] push_dat,
  output logic                  push_rdy,
  output logic                  pop_vld,
  output logic [DATA_WIDTH-1:0] pop_dat,
  input  logic                  pop_rdy
);

  localparam int PTR_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int CNT_W = $clog2(DATA_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  push_en, pop_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DATA_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_rdy = (cnt_q != CNT_W'(DATA_DEPTH));
  assign pop_vld  = (cnt_q != '0);
  assign push_en  = push_vld & push_rdy;
  assign pop_en   = pop_rdy & pop_vld;
  // Read data forced to zero when empty so downstream muxes idle at zero.
  assign pop_dat  = pop_vld ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_en) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_dw_allocator.sv
// Write-data allocator: forwards W beats from N target inputs to one master W port in AW grant order.
// Latency: 0 (combinational); 1 cycle when AXI_DW_ALLOC_OUT_REG_EN is defined (2-entry skid buffer).
// Backpressure: only the head-of-FIFO source sees ready, gated by master ready (or skid buffer space).
// Ports: slave_w* per-target W inputs/readies, master_w* forwarded W channel,
//        push_ID_i/ID_i/grant_FIFO_ID_o grant-order push interface from the AW allocator.
module axi_dw_allocator
  import axi_dw_allocator_pkg::*;
#(
  parameter int N_TARG_PORT = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int AXI_DATA_W  = AXI_DW_DATA_W,
  parameter int AXI_USER_W  = AXI_DW_USER_W
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]   slave_wdata_i,
  input  logic [N_TARG_PORT-1:0][AXI_DATA_W/8-1:0] slave_wstrb_i,
  input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]   slave_wuser_i,
  input  logic [N_TARG_PORT-1:0]                   slave_wlast_i,
  input  logic [N_TARG_PORT-1:0]                   slave_wvalid_i,
  output logic [N_TARG_PORT-1:0]                   slave_wready_o,
  output logic [AXI_DATA_W-1:0]                    master_wdata_o,
  output logic [AXI_DATA_W/8-1:0]                  master_wstrb_o,
  output logic [AXI_USER_W-1:0]                    master_wuser_o,
  output logic                                     master_wlast_o,
  output logic                                     master_wvalid_o,
  input  logic                                     master_wready_i,
  input  logic                                     push_ID_i,
  input  logic [N_TARG_PORT-1:0]                   ID_i,
  output logic                                     grant_FIFO_ID_o
);

  logic [N_TARG_PORT-1:0] fifo_dat, sel;
  logic                   fifo_vld, fifo_rdy;
  logic                   master_ready_int, in_vld, accept, pop;
  w_beat_t                in_beat;

  axi_dw_allocator_fifo #(
    .DATA_WIDTH (N_TARG_PORT),
    .DATA_DEPTH (FIFO_DEPTH)
  ) u_id_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_ID_i),
    .push_dat (ID_i),
    .push_rdy (fifo_rdy),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_dat),
    .pop_rdy  (pop)
  );

  // Held low during reset so the AW side never sees a grant before the FIFO is usable.
  assign grant_FIFO_ID_o = fifo_rdy & rst_n;
  assign sel             = fifo_vld ? fifo_dat : '0;

  // AND-OR mux: sel is one-hot (or zero), so OR-ing the selected inputs picks one source.
  always_comb begin
    in_beat = '0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      if (sel[i]) begin
        in_beat.data = in_beat.data | slave_wdata_i[i];
        in_beat.strb = in_beat.strb | slave_wstrb_i[i];
        in_beat.user = in_beat.user | slave_wuser_i[i];
        in_beat.last = in_beat.last | slave_wlast_i[i];
      end
    end
  end

  assign in_vld         = |(slave_wvalid_i & sel);
  assign slave_wready_o = sel & {N_TARG_PORT{master_ready_int}};
  assign accept         = in_vld & master_ready_int;
  // Popping on the accepted last beat lets the next burst's head be used on the following cycle.
  assign pop            = accept & in_beat.last;

`ifdef AXI_DW_ALLOC_OUT_REG_EN
  // Two-entry skid buffer: entry 0 drives the outputs, entry 1 absorbs a beat while stalled.
  w_beat_t    skid_q [2];
  logic [1:0] skid_cnt_q;
  logic       out_pop;

  // Ready upstream depends only on local occupancy, cutting the master_wready_i path.
  assign master_ready_int = (skid_cnt_q != 2'd2);
  assign out_pop          = (skid_cnt_q != 2'd0) & master_wready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      skid_cnt_q <= 2'd0;
    end else begin
      case ({accept, out_pop})
        2'b10: begin
          if (skid_cnt_q == 2'd0) skid_q[0] <= in_beat;
          else                    skid_q[1] <= in_beat;
          skid_cnt_q <= skid_cnt_q + 2'd1;
        end
        2'b01: begin
          skid_q[0]  <= skid_q[1];
          skid_cnt_q <= skid_cnt_q - 2'd1;
        end
        2'b11: begin
          if (skid_cnt_q == 2'd1) begin
            skid_q[0] <= in_beat;
          end else begin
            skid_q[0] <= skid_q[1];
            skid_q[1] <= in_beat;
          end
        end
        default: skid_cnt_q <= skid_cnt_q;
      endcase
    end
  end

  assign master_wvalid_o = (skid_cnt_q != 2'd0);
  assign master_wdata_o  = skid_q[0].data;
  assign master_wstrb_o  = skid_q[0].strb;
  assign master_wuser_o  = skid_q[0].user;
  assign master_wlast_o  = skid_q[0].last;
`else
  assign master_ready_int = master_wready_i;
  assign master_wvalid_o  = in_vld;
  assign master_wdata_o   = in_beat.data;
  assign master_wstrb_o   = in_beat.strb;
  assign master_wuser_o   = in_beat.user;
  assign master_wlast_o   = in_beat.last;
`endif

endmodule
